// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port register file with one write port and two
// registered read ports.
//
// Ports:
//   clk        : sole clock, rising-edge active
//   reset      : synchronous active-high reset; clears registers, read
//                outputs and valid flags
//   write      : write enable
//   writenum   : write address (AW bits); addresses >= NREGS are ignored
//   data_in    : write data (WIDTH bits)
//   readnum_a  : read port A address
//   readnum_b  : read port B address
//   data_out_a : registered read data, port A (0 for addresses >= NREGS)
//   data_out_b : registered read data, port B (0 for addresses >= NREGS)
//   valid      : bit i set once register i has been written since reset
//
// Configuration macro REGFILE_MP_BYPASS_EN:
//   defined   -> write-first: a read of the address being written on the
//                same edge returns data_in
//   undefined -> read-first: that read returns the pre-write value
module regfile_mp #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [AW-1:0]    writenum,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    readnum_a,
    input  logic [AW-1:0]    readnum_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b,
    output logic [NREGS-1:0] valid
);

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // One extra bit so the register count itself is representable when
    // NREGS is an exact power of two.
    localparam logic [AW:0] NREGS_A = (AW + 1)'(NREGS);

    logic [WIDTH-1:0] regs [NREGS];

    logic             wr_ok;
    logic             in_a;
    logic             in_b;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;

    always_comb begin
        wr_ok  = write && ({1'b0, writenum} < NREGS_A);
        in_a   = {1'b0, readnum_a} < NREGS_A;
        in_b   = {1'b0, readnum_b} < NREGS_A;
        next_a = '0;
        next_b = '0;
        if (in_a) begin
            next_a = regs[readnum_a];
            // Write-first forwarding applies to each port on its own.
            if (BYPASS && wr_ok && (readnum_a == writenum)) begin
                next_a = data_in;
            end
        end
        if (in_b) begin
            next_b = regs[readnum_b];
            if (BYPASS && wr_ok && (readnum_b == writenum)) begin
                next_b = data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs       <= '{default: '0};
            valid      <= '0;
            data_out_a <= '0;
            data_out_b <= '0;
        end else begin
            if (wr_ok) begin
                regs[writenum]  <= data_in;
                valid[writenum] <= 1'b1;
            end
            data_out_a <= next_a;
            data_out_b <= next_b;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- scoreboard bench for regfile_mp. Three instances cover
// the default geometry (16x8), a non-power-of-two count (16x6) and a wide
// file (32x16). Stimulus pushes the expected response of each edge into a
// queue; a monitor pops one entry per edge and compares.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        int          sel;
        bit          ca;
        logic [31:0] ea;
        bit          cb;
        logic [31:0] eb;
        bit          cv;
        logic [15:0] ev;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        w8 = 1'b0, w6 = 1'b0, w32 = 1'b0;
    logic [2:0]  wn8 = '0, ra8 = '0, rb8 = '0;
    logic [15:0] d8 = '0;
    logic [2:0]  wn6 = '0, ra6 = '0, rb6 = '0;
    logic [15:0] d6 = '0;
    logic [3:0]  wn32 = '0, ra32 = '0, rb32 = '0;
    logic [31:0] d32 = '0;

    logic [15:0] a8, b8, a6, b6;
    logic [31:0] a32, b32;
    logic [7:0]  v8;
    logic [5:0]  v6;
    logic [15:0] v32;

    regfile_mp #(.WIDTH(16), .NREGS(8)) dut8 (
        .clk(clk), .reset(rst), .write(w8), .writenum(wn8), .data_in(d8),
        .readnum_a(ra8), .readnum_b(rb8),
        .data_out_a(a8), .data_out_b(b8), .valid(v8)
    );

    regfile_mp #(.WIDTH(16), .NREGS(6)) dut6 (
        .clk(clk), .reset(rst), .write(w6), .writenum(wn6), .data_in(d6),
        .readnum_a(ra6), .readnum_b(rb6),
        .data_out_a(a6), .data_out_b(b6), .valid(v6)
    );

    regfile_mp #(.WIDTH(32), .NREGS(16)) dut32 (
        .clk(clk), .reset(rst), .write(w32), .writenum(wn32), .data_in(d32),
        .readnum_a(ra32), .readnum_b(rb32),
        .data_out_a(a32), .data_out_b(b32), .valid(v32)
    );

    int n_pass = 0;
    int n_total = 0;

    function automatic exp_t mk(input string n, input int sel,
                                input bit ca, input logic [31:0] ea,
                                input bit cb, input logic [31:0] eb,
                                input bit cv, input logic [15:0] ev);
        exp_t e;
        e.name = n; e.sel = sel;
        e.ca = ca; e.ea = ea;
        e.cb = cb; e.eb = eb;
        e.cv = cv; e.ev = ev;
        return e;
    endfunction

    task automatic step8(input bit r, input bit w, input logic [2:0] wn,
                         input logic [15:0] d, input logic [2:0] ra,
                         input logic [2:0] rb, input exp_t e);
        @(negedge clk);
        rst = r; w8 = w; wn8 = wn; d8 = d; ra8 = ra; rb8 = rb;
        w6 = 1'b0; w32 = 1'b0;
        sb.push_back(e);
    endtask

    task automatic step6(input bit w, input logic [2:0] wn,
                         input logic [15:0] d, input logic [2:0] ra,
                         input logic [2:0] rb, input exp_t e);
        @(negedge clk);
        rst = 1'b0; w6 = w; wn6 = wn; d6 = d; ra6 = ra; rb6 = rb;
        w8 = 1'b0; w32 = 1'b0;
        sb.push_back(e);
    endtask

    task automatic step32(input bit w, input logic [3:0] wn,
                          input logic [31:0] d, input logic [3:0] ra,
                          input logic [3:0] rb, input exp_t e);
        @(negedge clk);
        rst = 1'b0; w32 = w; wn32 = wn; d32 = d; ra32 = ra; rb32 = rb;
        w8 = 1'b0; w6 = 1'b0;
        sb.push_back(e);
    endtask

    // Monitor: one scoreboard entry describes the outputs after one edge.
    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    initial begin
        exp_t e;
        logic [31:0] aa, bb, vv;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sel)
                    0:       begin aa = {16'h0, a8};  bb = {16'h0, b8};  vv = {24'h0, v8}; end
                    1:       begin aa = {16'h0, a6};  bb = {16'h0, b6};  vv = {26'h0, v6}; end
                    default: begin aa = a32;          bb = b32;          vv = {16'h0, v32}; end
                endcase
                if (e.ca) chk({e.name, ".a"}, aa, e.ea);
                if (e.cb) chk({e.name, ".b"}, bb, e.eb);
                if (e.cv) chk({e.name, ".valid"}, vv, {16'h0, e.ev});
            end
        end
    end

    initial begin
        int guard;
        // Reset all instances.
        step8(1, 0, 0, 16'h0, 0, 0, mk("rst0", 0, 0, 0, 0, 0, 0, 0));
        step8(1, 0, 0, 16'h0, 0, 0, mk("rst", 0, 1, 0, 1, 0, 1, 16'h00));

        // Fill R0..R7 with ABCD; each register is read back on both ports
        // on the edge after its write.
        for (int i = 0; i <= 8; i++) begin
            logic [2:0]  wa;
            logic [2:0]  rd;
            logic [15:0] ev;
            wa = 3'(i);
            rd = (i == 0) ? 3'd0 : 3'(i - 1);
            ev = (i >= 7) ? 16'h00FF : 16'((32'h1 << (i + 1)) - 1);
            step8(0, i < 8, wa, 16'hABCD, rd, rd,
                  mk($sformatf("fill%0d", i), 0, i > 0, 32'hABCD,
                     i > 0, 32'hABCD, 1, ev));
        end

        // Two ports reading different registers on the same edge.
        step8(0, 1, 2, 16'h1234, 0, 0, mk("w2", 0, 0, 0, 0, 0, 0, 0));
        step8(0, 1, 5, 16'h5678, 0, 0, mk("w5", 0, 0, 0, 0, 0, 0, 0));
        step8(0, 0, 0, 16'h0, 2, 5, mk("rd25", 0, 1, 32'h1234, 1, 32'h5678, 1, 16'hFF));

        // Same-edge write/read collision on port A; port B reads elsewhere.
        step8(0, 1, 3, 16'h0001, 0, 0, mk("w3", 0, 0, 0, 0, 0, 0, 0));
        step8(0, 1, 3, 16'hBEEF, 3, 2,
              mk("raw3", 0, 1, BYP ? 32'hBEEF : 32'h0001, 1, 32'h1234, 0, 0));
        step8(0, 0, 0, 16'h0, 3, 3, mk("after3", 0, 1, 32'hBEEF, 1, 32'hBEEF, 0, 0));

        // Reset priority over a pending write.
        step8(1, 0, 0, 16'h0, 0, 0, mk("rst2", 0, 1, 0, 1, 0, 1, 16'h00));
        step8(0, 1, 4, 16'hFFFF, 0, 0, mk("w4", 0, 1, 0, 1, 0, 1, 16'h10));
        step8(0, 0, 0, 16'h0, 4, 4, mk("rd4", 0, 1, 32'hFFFF, 1, 32'hFFFF, 1, 16'h10));
        step8(1, 1, 4, 16'h00AA, 4, 4, mk("rstw", 0, 1, 0, 1, 0, 1, 16'h00));
        step8(0, 0, 0, 16'h0, 4, 4, mk("drop", 0, 1, 0, 1, 0, 1, 16'h00));

        // First write after reset, read on the same edge through port A.
        step8(1, 0, 0, 16'h0, 0, 0, mk("rst3", 0, 0, 0, 0, 0, 0, 0));
        step8(0, 1, 1, 16'h0055, 1, 0,
              mk("first", 0, 1, BYP ? 32'h0055 : 32'h0, 1, 0, 1, 16'h02));
        step8(0, 0, 0, 16'h0, 1, 1, mk("first_rd", 0, 1, 32'h0055, 1, 32'h0055, 1, 16'h02));

        // NREGS=6: out-of-range writes and reads.
        step6(1, 5, 16'h6666, 0, 0, mk("n6_w5", 1, 0, 0, 0, 0, 1, 16'h20));
        step6(1, 7, 16'h7777, 7, 5, mk("n6_w7", 1, 1, 0, 1, 32'h6666, 1, 16'h20));
        step6(1, 6, 16'h7777, 6, 1, mk("n6_w6", 1, 1, 0, 1, 0, 1, 16'h20));
        step6(0, 0, 16'h0, 7, 5, mk("n6_rd", 1, 1, 0, 1, 32'h6666, 1, 16'h20));

        // WIDTH=32, NREGS=16: top register.
        step32(1, 15, 32'hDEADBEEF, 0, 0, mk("w32", 2, 0, 0, 0, 0, 1, 16'h8000));
        step32(0, 0, 32'h0, 0, 15, mk("rd32", 2, 1, 0, 1, 32'hDEADBEEF, 1, 16'h8000));

        // Drain the scoreboard with a bounded wait.
        step8(0, 0, 0, 16'h0, 0, 0, mk("idle", 0, 0, 0, 0, 0, 0, 0));
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of every register in bits.
REQ-002 SHALL have parameter NREGS, default 8, register count; legal range 2..64; need not be a power of two.
REQ-003 SHALL derive localparam AW = $clog2(NREGS) for all address ports.
REQ-004 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-006 SHALL have port write  input  1  write enable.
REQ-007 SHALL have port writenum  input  AW  write address.
REQ-008 SHALL have port data_in  input  WIDTH  write data.
REQ-009 SHALL have port readnum_a  input  AW  read port A address.
REQ-010 SHALL have port readnum_b  input  AW  read port B address.
REQ-011 SHALL have port data_out_a  output  WIDTH  registered read data, port A.
REQ-012 SHALL have port data_out_b  output  WIDTH  registered read data, port B.
REQ-013 SHALL have port valid  output  NREGS  bit i set means register i has been written since the last reset.

Function
REQ-014 SHALL write data_in into register writenum on a rising clk edge where write=1, reset=0 and writenum<NREGS.
REQ-015 SHALL ignore a write with writenum>=NREGS: no register change and no valid change.
REQ-016 SHALL give reads a latency of one cycle: data_out_x after edge n = register[readnum_x sampled at edge n].
REQ-017 SHALL drive data_out_x to 0 after an edge where readnum_x>=NREGS.
REQ-018 SHALL allow both ports to read the same address in the same cycle, returning identical data.
REQ-019 SHALL hold data_out_x between edges; outputs change only on a rising clk edge.
REQ-020 SHALL set valid[writenum] on every accepted write; bits are cleared only by reset.
REQ-021 SHALL resolve a same-edge write and read to the same address per REQ-031/REQ-032.
REQ-022 SHALL update at most one register per cycle; all other registers hold.

Reset
REQ-023 SHALL clear every register to 0 on a rising clk edge with reset=1.
REQ-024 SHALL clear data_out_a, data_out_b and valid to 0 on the same edge.
REQ-025 SHALL give reset priority over write: a write presented with reset=1 is dropped.
REQ-026 SHALL accept a write on the first edge with reset=0; a read on that edge returns 0 or bypassed data per REQ-031.
REQ-027 SHALL leave the register and output state before the first reset undefined. A bench SHALL reset before the first check.

Configuration
REQ-028 SHALL use macro REGFILE_MP_BYPASS_EN to select same-cycle read-after-write behaviour.
REQ-029 SHALL have an identical port list in both builds.
REQ-030 SHALL apply REQ-031 and REQ-032 to each read port independently.
REQ-031 With REGFILE_MP_BYPASS_EN defined: SHALL return data_in on data_out_x after an edge with write=1, reset=0 and readnum_x==writenum<NREGS (write-first).
REQ-032 With REGFILE_MP_BYPASS_EN undefined: SHALL return the pre-write register value in that case (read-first); the new value is visible one edge later.

Verification
REQ-033 Reset, then write 16'hABCD to each of R0..R7 in turn, reading each back on both ports next cycle -> data_out_a=data_out_b=16'hABCD; valid=8'hFF after the last write.
REQ-034 Write R2=16'h1234 and R5=16'h5678; readnum_a=2 and readnum_b=5 on the same edge -> next cycle data_out_a=16'h1234, data_out_b=16'h5678.
REQ-035 R3 holds 16'h0001; same edge: write=1, writenum=3, data_in=16'hBEEF, readnum_a=3 -> data_out_a=16'hBEEF with REGFILE_MP_BYPASS_EN, else 16'h0001 then 16'hBEEF one edge later.
REQ-036 R4=16'hFFFF and valid=8'h10; assert reset with write=1, writenum=4, data_in=16'h00AA -> R4=0, valid=0, data_out_a=data_out_b=0.
REQ-037 NREGS=6: write=1, writenum=7, data_in=16'h7777 -> no register or valid change; readnum_a=7 -> data_out_a=0.
REQ-038 WIDTH=32, NREGS=16: write 32'hDEADBEEF to R15 and read it on port B -> data_out_b=32'hDEADBEEF; valid[15]=1.
